button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Upstream input stage for the 7-segment counter. Takes raw board pushbuttons
//  (start, progressive, regressive) and conditions them for the counter-control
//  StateMachine: 2-FF synchronise, per-channel debounce, then produce a stable
//  level plus single-cycle press/release pulses. The StateMachine consumes only
//  the clean press pulses, never raw pins.
// PARAMETERS
//  N_BTN            3          number of independent button channels
//  DEBOUNCE_CYCLES  1_000_000  cycles new value must hold (10 ms @ 100 MHz); >= 2
//  CNT_W            20         debounce counter width; >= clog2(DEBOUNCE_CYCLES)
// PORTS
//  clk_100MHz   in   1      system clock, all logic on rising edge
//  reset        in   1      asynchronous, active-high; clears all state
//  btn_raw      in   N_BTN  raw asynchronous pushbutton pins, 1 = pressed
//  btn_level    out  N_BTN  debounced stable level per channel
//  btn_press    out  N_BTN  1-cycle pulse on debounced 0->1 (to StateMachine)
//  btn_release  out  N_BTN  1-cycle pulse on debounced 1->0
// BEHAVIOUR
//  - Reset (async assert, sync use): sync FFs, counters, btn_level,
//    btn_press, btn_release all 0. No pulse generated by reset itself.
//  - Sync: s1 <= btn_raw; s2 <= s1. Only s2 enters debounce logic.
//  - Per channel, every cycle, one counter cnt[CNT_W-1:0]:
//    * s2 == level        -> cnt <= 0 (any bounce restarts qualification)
//    * s2 != level, cnt <  DEBOUNCE_CYCLES-1 -> cnt <= cnt+1
//    * s2 != level, cnt == DEBOUNCE_CYCLES-1 -> level <= s2, cnt <= 0,
//      press <= s2, release <= ~s2 (same edge as level update)
//  - press/release are registered, high exactly 1 cycle, default 0;
//    press and release of one channel never high together.
//  - Latency: raw change first sampled at edge k -> level and pulse change
//    at edge k+1+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES+2 edges counting k).
//  - Any input excursion shorter than DEBOUNCE_CYCLES consecutive s2 cycles
//    is filtered: no level change, no pulse.
//  - Held button: exactly one press; no auto-repeat; level stays 1.
//  - Channels fully independent; simultaneous qualified edges on several
//    channels give pulses in the same cycle. No priority/mutual exclusion
//    here (StateMachine resolves progressive vs regressive).
//  - Counter never wraps: it resets on qualify or on match, max value is
//    DEBOUNCE_CYCLES-1.
//  - Reset mid-count: state cleared immediately; a button held through reset
//    re-qualifies from level 0 and yields one press DEBOUNCE_CYCLES+2 edges
//    after the first post-reset sampling edge.
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//  1 clean press: btn_raw[0] 0->1 sampled edge 1 -> btn_level[0]=1 and
//    btn_press[0]=1 at edge 6; btn_press[0]=0 at edge 7; other channels 0.
//  2 bounce: btn_raw[1] toggles every 2 cycles x20, then holds 1 -> no
//    pulse during bounce; single btn_press[1] 6 edges after final transition.
//  3 release: from level 1, btn_raw[0] 1->0 -> btn_release[0] 1 cycle at
//    edge 6, btn_level[0]=0, btn_press[0] stays 0.
//  4 glitch: btn_raw[2] high for 3 cycles then low -> btn_level[2],
//    btn_press[2] remain 0 throughout.
//  5 simultaneous: btn_raw[0] and btn_raw[2] rise same cycle -> both
//    press bits high in same single cycle; btn_press[1]=0.
//  6 reset mid-count: raw[0] held, reset asserted after 2 counting edges ->
//    outputs 0 at once, no pulse; after release, press 6 edges post-reset.

Source files
------------

// File: rtl/button_conditioner.sv
// Pushbutton input stage: 2-FF synchroniser, per-channel debounce counter, and
// registered stable level plus single-cycle press/release pulses.
module button_conditioner #(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    // Any sample agreeing with the current level restarts qualification.
    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                cnt_d[i]     = '0;
                level_d[i]   = sync2_q[i];
                press_d[i]   = sync2_q[i];
                release_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized hold lengths,
// checked against a sliding-window model of the synchronised input history.
module tb_button_conditioner;

    localparam int unsigned N = 3;
    localparam int unsigned D = 4;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (W)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: a level flips once the last D synchronised samples all disagree with it.
    logic [N-1:0] samp [$];
    logic [N-1:0] m_level, m_press, m_release;

    int           first_press, first_rel, pulse_cnt;
    logic [N-1:0] press_mask;

    task automatic chk_v(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        for (int k = 0; k < int'(D) + 1; k++) samp.push_back('0);
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
    endtask

    // samp holds raw samples; the oldest D entries are what the debouncer sees now.
    task automatic model_edge(input logic [N-1:0] raw);
        samp.push_back(raw);
        m_press   = '0;
        m_release = '0;
        for (int ch = 0; ch < int'(N); ch++) begin
            bit all_diff = 1'b1;
            for (int k = 0; k < int'(D); k++) begin
                if (samp[k][ch] == m_level[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_level[ch] = ~m_level[ch];
                if (m_level[ch]) m_press[ch] = 1'b1;
                else m_release[ch] = 1'b1;
            end
        end
        void'(samp.pop_front());
    endtask

    task automatic step(input logic [N-1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        chk_v("level", btn_level, m_level);
        chk_v("press", btn_press, m_press);
        chk_v("release", btn_release, m_release);
        chk_v("press_and_release", btn_press & btn_release, '0);
    endtask

    // Hold raw for n edges; record the first pulse edges (1-based) and pulse count.
    task automatic run_hold(input logic [N-1:0] raw, input int n);
        first_press = -1;
        first_rel   = -1;
        pulse_cnt   = 0;
        press_mask  = '0;
        for (int e = 1; e <= n; e++) begin
            step(raw);
            if (btn_press != '0 && first_press < 0) begin
                first_press = e;
                press_mask  = btn_press;
            end
            if (btn_release != '0 && first_rel < 0) first_rel = e;
            if (btn_press != '0 || btn_release != '0) pulse_cnt++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk_v("rst_level", btn_level, '0);
        chk_v("rst_press", btn_press, '0);
        chk_v("rst_release", btn_release, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int bounce_pulses;
        reset   = 1'b0;
        btn_raw = '0;
        model_reset();
        #2;
        apply_reset();

        // clean press on channel 0
        run_hold(3'b001, 8);
        chk_i("t1_press_edge", first_press, 6);
        chk_v("t1_press_mask", press_mask, 3'b001);
        chk_i("t1_pulses", pulse_cnt, 1);
        chk_v("t1_level", btn_level, 3'b001);

        // release on channel 0
        run_hold(3'b000, 8);
        chk_i("t3_release_edge", first_rel, 6);
        chk_i("t3_press_edge", first_press, -1);
        chk_v("t3_level", btn_level, 3'b000);

        // bounce on channel 1, then settle high
        bounce_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            run_hold((i % 2 == 0) ? 3'b010 : 3'b000, 2);
            bounce_pulses += pulse_cnt;
        end
        chk_i("t2_bounce_pulses", bounce_pulses, 0);
        run_hold(3'b010, 8);
        chk_i("t2_press_edge", first_press, 6);
        chk_v("t2_press_mask", press_mask, 3'b010);
        run_hold(3'b000, 8);

        // short glitch on channel 2
        run_hold(3'b100, 3);
        chk_i("t4_glitch_pulses_hi", pulse_cnt, 0);
        run_hold(3'b000, 8);
        chk_i("t4_glitch_pulses_lo", pulse_cnt, 0);
        chk_v("t4_level", btn_level, 3'b000);

        // simultaneous press on channels 0 and 2, held long: no auto-repeat
        run_hold(3'b101, 30);
        chk_i("t5_press_edge", first_press, 6);
        chk_v("t5_press_mask", press_mask, 3'b101);
        chk_i("t5_pulses", pulse_cnt, 1);
        run_hold(3'b000, 8);

        // reset mid-count with channel 0 held through it
        run_hold(3'b001, 3);
        chk_i("t6_pre_pulses", pulse_cnt, 0);
        apply_reset();
        run_hold(3'b001, 8);
        chk_i("t6_press_edge", first_press, 6);
        chk_i("t6_pulses", pulse_cnt, 1);
        run_hold(3'b000, 8);

        // randomized hold lengths, occasional reset
        for (int seg = 0; seg < 150; seg++) begin
            logic [N-1:0] v;
            v = N'($urandom);
            run_hold(v, int'($urandom_range(1, 8)));
            if ($urandom_range(0, 29) == 0) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
